filter_iir_axil_slave: RTL and testbench
========================================

Name: filter_iir_axil_slave

Overview:
AXI4-Lite responder (slave) register file for the IIR filter IP. It terminates the S00_AXI port that the block-design master drives. It exposes four read/write configuration words to the filter datapath and four read-only status words from it. Write and read channels are independent, fully registered, and backpressure-safe.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots, decoded from ADDR[4:2].
CFG_RESET_VAL, 32'h0, reset value of all four config registers.

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte-lane enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
cfg_regs  out  128  config words 0..3; word n is at bits [32n+31:32n]
cfg_wr_stb  out  4  one-cycle pulse per config word that was written
sts_in  in  128  status words 0..3, sampled at read time

Behaviour:
- Reset: one clock, S_AXI_ACLK. S_AXI_ARESETN is asynchronous active-low.
  - All READY and VALID outputs go to 0. BRESP, RRESP and RDATA go to 0. cfg_regs goes to CFG_RESET_VAL in every word. cfg_wr_stb goes to 0.
  - Captured AW/W state is discarded.
  - Reset asserted mid-transaction drops the transaction. No B or R beat is issued for it afterwards.
- Address map (word index ADDR[4:2]):
  - 0..3 (0x00..0x0C): read/write config words.
  - 4..7 (0x10..0x1C): read-only, return sts_in words 0..3.
  - ADDR[1:0] is ignored.
- Write path, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY=1 until an address is captured; WREADY=1 until data is captured. AW and W may arrive in either order or in the same cycle. Each is latched independently and its READY drops after capture.
  - When both are held, the commit happens on the next edge:
    - config word is updated per WSTRB byte lane;
    - matching cfg_wr_stb bit pulses high for exactly one cycle, even if WSTRB is 0;
    - BVALID=1 with BRESP=OKAY; state moves to W_RESP.
  - Latency: AW and W in the same cycle gives BVALID on the next cycle.
  - W_RESP: BVALID and BRESP are held stable until BREADY. AWREADY and WREADY stay 0. The cycle after the B handshake, return to W_IDLE with both READYs at 1.
  - Writes to slots 4..7 change nothing, produce no strobe, and return OKAY.
- Read path, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1.
  - On the AR handshake, RDATA is loaded from the slot's current value (config register or sts_in), RVALID=1, RRESP=OKAY, and state moves to R_RESP. Latency is 1 cycle.
  - R_RESP: ARREADY=0. RDATA and RVALID are held until RREADY. Return to R_IDLE the cycle after the handshake.
- Simultaneous events:
  - A read and a write commit to the same config word on the same edge: the read returns the pre-write value.
  - Read and write paths never stall each other.
- Outstanding transactions: at most one write and one read are outstanding.

Optional Feature:
FILTER_IIR_AXIL_SLVERR_EN.
- Defined:
  - A write to slots 4..7 returns BRESP=SLVERR (2'b10), with no state change and no strobe.
  - A write with WSTRB=4'b0000 to a config slot returns SLVERR, with no update and no strobe.
  - Reads are always OKAY.
- Undefined: all responses are OKAY, as described in Behaviour.

Test Plan:
- Release reset at 100 ns. Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read them back -> RDATA 0x1, 0x2, 0x3, 0x4; RRESP=0 and BRESP=0 on every beat; cfg_regs=0x00000004_00000003_00000002_00000001; cfg_wr_stb pulses 0001, 0010, 0100, 1000.
- W presented 3 cycles before AW (addr 0x08, data 0xDEADBEEF); hold BREADY low for 4 cycles -> BVALID rises 1 cycle after AW capture and stays stable; AWREADY and WREADY remain 0 until the cycle after the B handshake.
- Partial write: WSTRB=4'b0010, data 0xAABBCCDD to 0x00 holding 0x11223344 -> read returns 0x1122CC44.
- Drive sts_in word 2 to 0xCAFEF00D, read 0x18 -> 0xCAFEF00D. Write 0x5 to 0x18 -> no strobe; BRESP=OKAY, or SLVERR with FILTER_IIR_AXIL_SLVERR_EN.
- Same-edge read and write commit on 0x04 (old value 0x2, new value 0x9) -> read returns 0x2; a following read returns 0x9.
- Assert S_AXI_ARESETN low while BVALID=1 and RVALID=1 -> both VALIDs drop immediately and asynchronously; after release, all config words read CFG_RESET_VAL.

Source files
------------

// File: rtl/filter_iir_axil_slave.sv
// AXI4-Lite register file for the IIR filter: four R/W config words, four read-only status words.
// Define FILTER_IIR_AXIL_SLVERR_EN to answer status-slot and empty-strobe writes with SLVERR.
`timescale 1ns/1ps
module filter_iir_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] CFG_RESET_VAL      = 32'h0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [3:0]                        S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   cfg_regs,
  output logic [3:0]                        cfg_wr_stb,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   sts_in
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t    w_state, w_state_next;
  r_state_t    r_state, r_state_next;
  logic        aw_held, aw_held_next, w_held, w_held_next;
  logic        aw_rdy, aw_rdy_next, w_rdy, w_rdy_next, ar_rdy, ar_rdy_next;
  logic [2:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [1:0]  bresp, bresp_next;
  logic [3:0]  stb, stb_next;
  logic [31:0] rdata, rdata_next, rd_word;
  logic [31:0] cfg_q [4];
  logic        aw_fire, w_fire, ar_fire, commit, wr_accept, wr_err;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // A beat arriving this cycle counts as held, so AW+W together commit on the same edge.
  always_comb begin
    aw_fire = S_AXI_AWVALID & aw_rdy;
    w_fire  = S_AXI_WVALID & w_rdy;
    wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[4:2];
    wr_data = w_held ? w_data : S_AXI_WDATA;
    wr_strb = w_held ? w_strb : S_AXI_WSTRB;
    commit  = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
`ifdef FILTER_IIR_AXIL_SLVERR_EN
    wr_accept = commit & ~wr_idx[2] & (wr_strb != 4'b0000);
    wr_err    = commit & ~wr_accept;
`else
    wr_accept = commit & ~wr_idx[2];
    wr_err    = 1'b0;
`endif
  end

  always_comb begin
    w_state_next = w_state;
    aw_held_next = aw_held | aw_fire;
    w_held_next  = w_held | w_fire;
    bresp_next   = bresp;
    stb_next     = 4'b0000;
    case (w_state)
      W_IDLE: begin
        if (commit) begin
          w_state_next = W_RESP;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
          bresp_next   = wr_err ? RESP_SLVERR : RESP_OKAY;
          if (wr_accept) stb_next[wr_idx[1:0]] = 1'b1;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    aw_rdy_next = (w_state_next == W_IDLE) & ~aw_held_next;
    w_rdy_next  = (w_state_next == W_IDLE) & ~w_held_next;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_rdy  <= 1'b0;
      w_rdy   <= 1'b0;
      bresp   <= RESP_OKAY;
      stb     <= 4'b0000;
      for (int n = 0; n < 4; n++) cfg_q[n] <= CFG_RESET_VAL;
    end else begin
      w_state <= w_state_next;
      aw_held <= aw_held_next;
      w_held  <= w_held_next;
      aw_rdy  <= aw_rdy_next;
      w_rdy   <= w_rdy_next;
      bresp   <= bresp_next;
      stb     <= stb_next;
      if (wr_accept) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) cfg_q[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Captured beat payload; only meaningful while the matching held flag is set.
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_fire) aw_idx <= S_AXI_AWADDR[4:2];
    if (w_fire) begin
      w_data <= S_AXI_WDATA;
      w_strb <= S_AXI_WSTRB;
    end
  end

  // Read samples cfg_q before any same-edge write lands, so it returns the old value.
  always_comb begin
    ar_fire      = S_AXI_ARVALID & ar_rdy;
    rd_idx       = S_AXI_ARADDR[4:2];
    rd_word      = rd_idx[2] ? sts_in[{rd_idx[1:0], 5'b00000} +: 32] : cfg_q[rd_idx[1:0]];
    r_state_next = r_state;
    rdata_next   = rdata;
    case (r_state)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_next = R_RESP;
          rdata_next   = rd_word;
        end
      end
      R_RESP: if (S_AXI_RREADY) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
    ar_rdy_next = (r_state_next == R_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      r_state <= r_state_next;
      ar_rdy  <= ar_rdy_next;
      rdata   <= rdata_next;
    end
  end

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = w_rdy;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = (r_state == R_RESP);
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign cfg_wr_stb    = stb;
  assign cfg_regs      = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};

endmodule

// File: tb/tb_filter_iir_axil_slave.sv
// Scoreboard bench for filter_iir_axil_slave: drivers queue expected B/R/strobe beats, a monitor checks them.
`timescale 1ns/1ps
module tb_filter_iir_axil_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, cfg_wr_stb;
  logic [1:0]   bresp, rresp;
  logic [127:0] cfg_regs, sts_in;

  int checks = 0;
  int errors = 0;
  logic [1:0]  b_q [$];
  logic [31:0] r_q [$];
  logic [3:0]  s_q [$];

`ifdef FILTER_IIR_AXIL_SLVERR_EN
  localparam logic [1:0] STS_WR_RESP = 2'b10;
  localparam logic [1:0] ZS_RESP     = 2'b10;
  localparam logic [3:0] ZS_STB      = 4'b0000;
`else
  localparam logic [1:0] STS_WR_RESP = 2'b00;
  localparam logic [1:0] ZS_RESP     = 2'b00;
  localparam logic [3:0] ZS_STB      = 4'b1000;
`endif

  always #5 clk = ~clk;

  filter_iir_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .CFG_RESET_VAL(32'h0)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_regs(cfg_regs), .cfg_wr_stb(cfg_wr_stb), .sts_in(sts_in)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat completes on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) chk("b_unexpected", bvalid, 1'b0);
        else chk("bresp", bresp, b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) chk("r_unexpected", rvalid, 1'b0);
        else begin
          chk("rdata", rdata, r_q.pop_front());
          chk("rresp", rresp, 2'b00);
        end
      end
      if (cfg_wr_stb != 4'b0000) begin
        if (s_q.size() == 0) chk("stb_unexpected", cfg_wr_stb, 4'b0000);
        else chk("cfg_wr_stb", cfg_wr_stb, s_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    if (b_q.size() != 0 || r_q.size() != 0) chk("beat_timeout", b_q.size() + r_q.size(), 0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input logic [3:0] es);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int n = 0;
    b_q.push_back(er);
    if (es != 4'b0000) s_q.push_back(es);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      tick();
      if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin wvalid = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) chk("wr_handshake_timeout", {aw_done, w_done}, 2'b11);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_drained();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    bit done = 0, now;
    int n = 0;
    r_q.push_back(exp);
    araddr = a; arvalid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      now = arvalid && arready;
      tick();
      if (now) begin arvalid = 1'b0; done = 1; end
      n++;
    end
    if (!done) chk("rd_handshake_timeout", done, 1'b1);
    arvalid = 1'b0;
    wait_drained();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1; sts_in = '0;

    #90;
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("rst_cfg", cfg_regs, 128'h0);
    chk("rst_stb", cfg_wr_stb, 4'b0000);
    #10 rst_n = 1'b1;
    tick(); tick();
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);

    // Full-word writes and read-back.
    for (int i = 0; i < 4; i++) wr(5'(i * 4), 32'(i + 1), 4'hF, 2'b00, 4'(1 << i));
    for (int i = 0; i < 4; i++) rd(5'(i * 4), 32'(i + 1));
    chk("cfg_regs_all", cfg_regs, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW, B held off for four cycles.
    bready = 1'b0;
    b_q.push_back(2'b00); s_q.push_back(4'b0100);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); chk("w_early_ready", wready, 1'b1);
    tick(); wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("w_held_low", {wready, bvalid}, 2'b00);
      tick();
    end
    awaddr = 5'h08; awvalid = 1'b1;
    @(negedge clk); chk("aw_late_ready", {awready, bvalid}, 2'b10);
    tick(); awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("b_hold", {bvalid, bresp, awready, wready}, 5'b1_00_00);
      tick();
    end
    bready = 1'b1;
    @(negedge clk); chk("b_handshake_cycle", {bvalid, awready, wready}, 3'b100);
    tick();
    @(negedge clk); chk("after_b", {bvalid, awready, wready}, 3'b011);
    tick();
    chk("cfg_word2", cfg_regs[95:64], 32'hDEADBEEF);
    chk("queue_b_empty", b_q.size(), 0);

    // Partial byte-lane write.
    wr(5'h00, 32'h11223344, 4'hF, 2'b00, 4'b0001);
    wr(5'h00, 32'hAABBCCDD, 4'b0010, 2'b00, 4'b0001);
    rd(5'h00, 32'h1122CC44);

    // Status words and writes that must not touch config.
    sts_in[95:64] = 32'hCAFEF00D;
    rd(5'h18, 32'hCAFEF00D);
    wr(5'h18, 32'h5, 4'hF, STS_WR_RESP, 4'b0000);
    wr(5'h0C, 32'hFFFF, 4'b0000, ZS_RESP, ZS_STB);
    chk("cfg_after_status_wr", cfg_regs, 128'h00000004_DEADBEEF_00000002_1122CC44);

    // Read and write committing on the same edge to word 1.
    b_q.push_back(2'b00); s_q.push_back(4'b0010); r_q.push_back(32'h2);
    awaddr = 5'h04; wdata = 32'h9; wstrb = 4'hF; araddr = 5'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk); chk("same_edge_ready", {awready, wready, arready}, 3'b111);
    tick(); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_drained();
    rd(5'h04, 32'h9);

    // Reset while both responses are pending.
    bready = 1'b0; rready = 1'b0;
    s_q.push_back(4'b1000);
    awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF; araddr = 5'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    @(negedge clk); chk("pre_rst_valid", {bvalid, rvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_valid_drop", {bvalid, rvalid}, 2'b00);
    chk("async_cfg_reset", cfg_regs, 128'h0);
    bready = 1'b1; rready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("no_beat_after_rst", {bvalid, rvalid}, 2'b00);
    end
    for (int i = 0; i < 4; i++) rd(5'(i * 4), 32'h0);

    repeat (3) tick();
    chk("queues_drained", b_q.size() + r_q.size() + s_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
